boot_loader: RTL
================

Name: boot_loader

Overview:
Upstream of the single-cycle core. Receives a byte stream over a valid/ready handshake, assembles 32-bit little-endian words, and writes them into instruction SRAM through the SRAM write port (w_en/address/write_data). Holds the core in reset (cpu_rst) until a complete image with a correct checksum has been written. On a bad image it latches an error and keeps the core in reset.

Parameters:
BASE_ADDR, 16'h0000, byte address in IM where word 0 is written.
MAX_WORDS, 16384, largest accepted word count; a header above this is an error.

Ports:
sysclk  input  1  system clock; all state updates on the rising edge
sysrst  input  1  asynchronous active-high reset
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
im_w_en  output  4  IM byte write enables; 4'hF for one cycle per word, else 4'h0
im_addr  output  16  IM byte address for the write
im_wdata  output  32  IM write data
cpu_rst  output  1  reset to the core (Reg_PC rst); 1 until load completes
done  output  1  image loaded and verified
err  output  1  load failed (oversize count or checksum mismatch)

Behaviour:
- One clock (sysclk). Reset is asynchronous and active-high (sysrst). All outputs are registered except in_ready, which decodes state.
- Reset values: state=HDR0, in_ready=1 once out of reset, im_w_en=0, im_addr=BASE_ADDR, im_wdata=0, cpu_rst=1, done=0, err=0. Internal word count, word index, byte lane, and checksum are all 0.
- A byte is accepted only when in_valid && in_ready. in_data is ignored otherwise, and in_valid gaps of any length are allowed.
- Frame format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4*N payload bytes (each word little-endian, lowest byte first), then 1 checksum byte. The checksum is the XOR of payload bytes only, so N=0 expects 8'h00.
- State machine:
  - HDR0: accept CNT_LO -> HDR1.
  - HDR1: accept CNT_HI. If N > MAX_WORDS -> ERR. If N == 0 -> CSUM. Otherwise -> DATA.
  - DATA: accept bytes into lanes 0..3 and XOR each into the running checksum. On lane 3 accepted:
    - At the next edge, im_wdata = {byte3, byte2, byte1, byte0}, im_addr = BASE_ADDR + 4*word_idx (mod 2^16), and im_w_en = 4'hF for exactly one cycle.
    - word_idx increments, and lane resets to 0.
    - If word_idx was N-1 -> CSUM.
  - CSUM: accept one byte. If it equals the checksum -> DONE, else -> ERR.
  - DONE: in_ready=0, done=1, cpu_rst=0 (deasserted at the edge after the checksum byte). Terminal until sysrst.
  - ERR: in_ready=0, err=1, cpu_rst=1. Terminal until sysrst.
- in_ready is 1 in HDR0/HDR1/DATA/CSUM and 0 in DONE/ERR. There is no stall during the write pulse, because the next word needs 4 more bytes.
- Partially written words are never written. A stream that stops mid-word leaves the loader waiting in DATA, with no timeout.
- Words already written before an ERR stay in IM; cpu_rst stays high, so they are never executed.
- sysrst asserted at any point (mid-word, mid-header, during a write pulse) immediately forces reset values. The write pulse is dropped and the next frame starts from HDR0.
- im_addr wraps modulo 2^16 when BASE_ADDR + 4*word_idx overflows. No error is raised for the wrap.
- done and err are never high together.

Test Plan:
- Nominal load: stream 02 00 13 00 00 00 93 00 10 00 90.
  - Write 1: im_addr=0x0000, im_wdata=0x00000013.
  - Write 2: im_addr=0x0004, im_wdata=0x00100093.
  - Each write has im_w_en=F for one cycle.
  - After the 0x90 byte: done=1 and cpu_rst=0 at the following edge.
- Bad checksum: same frame with last byte 0x91. Two writes occur, then err=1, cpu_rst stays 1, in_ready=0, and further in_valid bytes are ignored.
- Zero/oversize count:
  - 00 00 00 -> done=1, no writes.
  - 01 40 (N=16385) -> err=1 immediately after CNT_HI, no writes.
- Handshake gaps: nominal frame with in_valid randomly low 0-5 cycles between bytes. Writes and done are identical to the nominal case; bytes with in_valid=0 have no effect.
- Reset mid-load: assert sysrst after 6 payload bytes (between edges). Outputs return to reset values asynchronously, the second word is never written, and a following nominal frame loads correctly from 0x0000.
- BASE_ADDR=16'hFFFC, N=2: writes land at 0xFFFC, then 0x0000 (wrap), and the load ends in done=1.

Source files
------------

// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction-SRAM write port of the boot loader.
// The slave modport is the loader side.
interface boot_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  im_w_en;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;

    modport slave  (input  in_valid, in_data,
                    output in_ready, im_w_en, im_addr, im_wdata);
    modport master (output in_valid, in_data,
                    input  in_ready, im_w_en, im_addr, im_wdata);
endinterface

// File: rtl/boot_loader.sv
// Boot loader: assembles a framed little-endian byte stream into IM words,
// verifies the XOR checksum and releases the core reset on success.
module boot_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 16384
) (
    input  logic         sysclk,
    input  logic         sysrst,
    boot_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         done,
    output logic         err
);
    typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

    state_t      r_state, w_next;
    logic [15:0] r_cnt, r_idx, r_addr;
    logic [1:0]  r_lane;
    logic [7:0]  r_csum;
    logic [23:0] r_buf;
    logic [31:0] r_wdata;
    logic [3:0]  r_w_en;
    logic        r_cpu_rst, r_done, r_err;
    logic        w_acc;
    logic [15:0] w_hdr_cnt;

    assign bus.in_ready = (r_state != DONE) && (r_state != ERR);
    assign w_acc        = bus.in_valid && bus.in_ready;
    assign w_hdr_cnt    = {bus.in_data, r_cnt[7:0]};

    assign bus.im_w_en  = r_w_en;
    assign bus.im_addr  = r_addr;
    assign bus.im_wdata = r_wdata;
    assign cpu_rst      = r_cpu_rst;
    assign done         = r_done;
    assign err          = r_err;

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) r_state <= HDR0;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HDR0: if (w_acc) w_next = HDR1;
            HDR1: if (w_acc) begin
                if ({1'b0, w_hdr_cnt} > LP_MAX) w_next = ERR;
                else if (w_hdr_cnt == 16'd0)    w_next = CSUM;
                else                            w_next = DATA;
            end
            DATA: if (w_acc && r_lane == 2'd3 && r_idx == r_cnt - 16'd1) w_next = CSUM;
            CSUM: if (w_acc) w_next = (bus.in_data == r_csum) ? DONE : ERR;
            default: w_next = r_state;
        endcase
    end

    // Status flags follow the next state so they line up with the state register.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_lane    <= '0;
            r_csum    <= '0;
            r_buf     <= '0;
            r_w_en    <= '0;
            r_addr    <= BASE_ADDR;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_w_en    <= 4'h0;
            r_done    <= (w_next == DONE);
            r_err     <= (w_next == ERR);
            r_cpu_rst <= (w_next != DONE);
            if (w_acc) begin
                case (r_state)
                    HDR0: r_cnt[7:0]  <= bus.in_data;
                    HDR1: r_cnt[15:8] <= bus.in_data;
                    DATA: begin
                        r_csum <= r_csum ^ bus.in_data;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_buf[7:0]   <= bus.in_data;
                            2'd1: r_buf[15:8]  <= bus.in_data;
                            2'd2: r_buf[23:16] <= bus.in_data;
                            default: begin
                                r_w_en  <= 4'hF;
                                r_wdata <= {bus.in_data, r_buf};
                                r_addr  <= BASE_ADDR + {r_idx[13:0], 2'b00};
                                r_idx   <= r_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
